// File: rtl/scan_display_arbiter.sv
// Multiplexed 4-digit display scanner shared by two requesters.
// Ownership and the digit snapshot are re-arbitrated only at frame boundaries.
module scan_display_arbiter #(
  parameter int          SCAN_DIV = 4,
  parameter int          BLANK    = 1,
  parameter logic [15:0] IDLE_PAT = 16'h0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req_a,
  input  logic [15:0] Data_a,
  input  logic        Req_b,
  input  logic [15:0] Data_b,
  output logic [3:0]  Seg,
  output logic [3:0]  Sl,
  output logic        Gnt_a,
  output logic        Gnt_b,
  output logic        Frame_done
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] BLANK_V   = SW'(BLANK);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

  logic [SW-1:0] slot;
  logic [1:0]    idx;
  owner_t        owner, owner_nxt;
  logic [15:0]   snap, snap_nxt;
  logic          slot_last;
  logic          frame_end;
  logic          in_blank;

  assign slot_last = (slot == SLOT_LAST);
  assign frame_end = slot_last && (idx == 2'd3);
  assign in_blank  = (BLANK != 0) && (slot < BLANK_V);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      slot  <= '0;
      idx   <= '0;
      owner <= OWN_NONE;
      snap  <= IDLE_PAT;
    end else begin
      slot  <= slot_last ? '0 : slot + 1'b1;
      if (slot_last)
        idx <= idx + 2'd1;
      owner <= owner_nxt;
      snap  <= snap_nxt;
    end
  end

  // Contention alternates away from the current owner; a fresh start favours A
  always_comb begin
    owner_nxt = owner;
    snap_nxt  = snap;
    if (frame_end) begin
      unique case ({Req_a, Req_b})
        2'b10:   owner_nxt = OWN_A;
        2'b01:   owner_nxt = OWN_B;
        2'b11:   owner_nxt = (owner == OWN_A) ? OWN_B : OWN_A;
        default: owner_nxt = OWN_NONE;
      endcase
      case (owner_nxt)
        OWN_A:   snap_nxt = Data_a;
        OWN_B:   snap_nxt = Data_b;
        default: snap_nxt = IDLE_PAT;
      endcase
    end
  end

  always_comb begin
    Seg = 4'h0;
    Sl  = 4'b1111;
    if (!in_blank) begin
      Seg = snap[4*idx +: 4];
      Sl  = ~(4'b0001 << idx);
    end
  end

  assign Gnt_a      = (owner == OWN_A);
  assign Gnt_b      = (owner == OWN_B);
  assign Frame_done = frame_end;

endmodule

// File: tb/tb_scan_display_arbiter.sv
// Randomized bench for scan_display_arbiter against a frame-level reference model.
module tb_scan_display_arbiter;

  localparam int          SD    = 4;
  localparam int          BL    = 1;
  localparam logic [15:0] IDLE  = 16'h0000;
  localparam int          FRAME = 4 * SD;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Req_a, Req_b;
  logic [15:0] Data_a, Data_b;
  logic [3:0]  Seg, Sl;
  logic        Gnt_a, Gnt_b, Frame_done;

  scan_display_arbiter #(.SCAN_DIV(SD), .BLANK(BL), .IDLE_PAT(IDLE)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req_a(Req_a), .Data_a(Data_a),
    .Req_b(Req_b), .Data_b(Data_b),
    .Seg(Seg), .Sl(Sl),
    .Gnt_a(Gnt_a), .Gnt_b(Gnt_b), .Frame_done(Frame_done)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc_abs = 0;

  // Reference model: position within the frame, owner (0 none, 1 A, 2 B), snapshot
  int          m_pos;
  int          m_own;
  logic [15:0] m_snap;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc_abs, got, exp);
    end
  endtask

  task automatic check_outputs();
    int slot, digit;
    logic [3:0] e_sl, e_seg;
    slot  = m_pos % SD;
    digit = m_pos / SD;
    if (slot < BL) begin
      e_sl  = 4'b1111;
      e_seg = 4'h0;
    end else begin
      e_sl  = 4'b1111;
      e_sl[digit] = 1'b0;
      e_seg = 4'((m_snap >> (4 * digit)) & 16'h000F);
    end
    chk("sl",         {12'h0, Sl},         {12'h0, e_sl});
    chk("seg",        {12'h0, Seg},        {12'h0, e_seg});
    chk("gnt_a",      {15'h0, Gnt_a},      {15'h0, (m_own == 1)});
    chk("gnt_b",      {15'h0, Gnt_b},      {15'h0, (m_own == 2)});
    chk("frame_done", {15'h0, Frame_done}, {15'h0, (m_pos == FRAME - 1)});
  endtask

  // Advance the model across one rising edge using the inputs now being driven
  task automatic model_edge();
    if (Reset) begin
      m_pos  = 0;
      m_own  = 0;
      m_snap = IDLE;
    end else begin
      if (m_pos == FRAME - 1) begin
        if (Req_a && Req_b)  m_own = (m_own == 1) ? 2 : 1;
        else if (Req_a)      m_own = 1;
        else if (Req_b)      m_own = 2;
        else                 m_own = 0;
        m_snap = (m_own == 1) ? Data_a : (m_own == 2) ? Data_b : IDLE;
      end
      m_pos = (m_pos + 1) % FRAME;
    end
  endtask

  task automatic step();
    model_edge();
    @(negedge Clk);
    cyc_abs++;
    check_outputs();
  endtask

  initial begin
    Reset  = 1'b1;
    Req_a  = 1'b0;
    Req_b  = 1'b0;
    Data_a = 16'h0;
    Data_b = 16'h0;
    m_pos  = 0;
    m_own  = 0;
    m_snap = IDLE;
    repeat (2) @(negedge Clk);
    check_outputs();

    // Both requesting continuously: owner alternates none, A, B, A, B
    Reset = 1'b0;
    Req_a = 1'b1; Req_b = 1'b1;
    Data_a = 16'h1111; Data_b = 16'h2222;
    for (int i = 0; i < 5 * FRAME; i++) step();

    // Only B with a non-BCD pattern
    Req_a = 1'b0; Data_b = 16'hFA0C;
    for (int i = 0; i < 2 * FRAME; i++) step();

    // A owns, then drops request and changes data mid-frame
    Req_a = 1'b1; Req_b = 1'b0; Data_a = 16'h4321;
    for (int i = 0; i < FRAME + 4; i++) step();
    Req_a = 1'b0; Data_a = 16'h8765;
    for (int i = 0; i < 2 * FRAME; i++) step();

    // Mid-frame reset while B owns
    Req_b = 1'b1;
    for (int i = 0; i < FRAME + 6; i++) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) step();

    // Random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      Req_a  = 1'($urandom_range(0, 1));
      Req_b  = 1'($urandom_range(0, 1));
      Data_a = 16'($urandom);
      Data_b = 16'($urandom);
      Reset  = ($urandom_range(0, 79) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/scan_display_arbiter.md
SCAN_DISPLAY_ARBITER -- requirements
Module: scan_display_arbiter

Interface
REQ-001 Parameter SCAN_DIV, default 4: clock cycles per digit slot; legal range 2..256.
REQ-002 Parameter BLANK, default 1: blanking cycles at the start of each digit slot; legal range 0..SCAN_DIV-1.
REQ-003 Parameter IDLE_PAT, default 16'h0000: digit pattern shown when no requester owns the display.
REQ-004 Clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Req_a  input  1  requester A wants the display.
REQ-007 Data_a  input  16  requester A digits; [3:0] = digit 0 … [15:12] = digit 3.
REQ-008 Req_b  input  1  requester B wants the display.
REQ-009 Data_b  input  16  requester B digits, same packing as Data_a.
REQ-010 Seg  output  4  code of the currently driven digit, to the external decoder.
REQ-011 Sl  output  4  active-low digit select; bit n low selects digit n.
REQ-012 Gnt_a  output  1  A owns the display for the current frame.
REQ-013 Gnt_b  output  1  B owns the display for the current frame.
REQ-014 Frame_done  output  1  one-cycle pulse in the last cycle of each frame.

Function
REQ-015 The block SHALL contain a slot counter (0..SCAN_DIV-1) and a digit index (0..3); the slot counter increments every cycle and wraps to 0 after SCAN_DIV-1, and the digit index increments on that wrap, wrapping 3->0.
REQ-016 A frame SHALL be 4*SCAN_DIV cycles: digit 0 through digit 3 in order.
REQ-017 While slot counter < BLANK, the block SHALL drive Sl=4'b1111 and Seg=4'h0.
REQ-018 Otherwise, the block SHALL drive Sl low only on bit[digit index] and Seg=snapshot[4*idx+3:4*idx].
REQ-019 Frame_done SHALL be high exactly when slot counter = SCAN_DIV-1 and digit index = 3.
REQ-020 At the clock edge ending a Frame_done cycle, the block SHALL arbitrate the owner for the next frame and load the 16-bit snapshot from the winner's data, or from IDLE_PAT if there is no winner.
REQ-021 Arbitration: only A requesting -> A; only B requesting -> B; neither -> none.
REQ-022 When both request, the block SHALL grant the one that is not the current owner; if the current owner is none, A wins.
REQ-023 Ownership and the snapshot SHALL NOT change mid-frame; req or data changes mid-frame take effect only at the next frame boundary.
REQ-024 Dropping a request mid-frame SHALL NOT revoke the grant before the frame boundary.
REQ-025 Gnt_a/Gnt_b SHALL be decoded from the owner register and are never both high.
REQ-026 Seg values SHALL pass through unmodified; non-BCD nibbles are displayed as-is.
REQ-027 Outputs SHALL be decoded from registers only, with no combinational path from Req_x/Data_x to any output.

Reset
REQ-028 While Reset is high at a rising edge: slot counter=0, digit index=0, owner=none, snapshot=IDLE_PAT.
REQ-029 Outputs after reset: Gnt_a=Gnt_b=0 and Frame_done=0; with BLANK>=1, Sl=4'b1111 and Seg=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame; the first frame after reset always shows IDLE_PAT.
REQ-031 Reset SHALL take priority over arbitration in the same cycle.

Verification (SCAN_DIV=4, BLANK=1, IDLE_PAT=16'h0000)
REQ-032 Reset, no requests -> each slot shows Sl=1111 for 1 cycle, then the digit select for 3 cycles (1110,1101,1011,0111); Seg=0; Frame_done in cycles 15, 31, ….
REQ-033 Req_a=1, Data_a=16'h4321 from reset -> frame 1 idle; from cycle 16 Gnt_a=1 and Seg=1,2,3,4 on digits 0..3.
REQ-034 Req_a=Req_b=1 held, Data_a=16'h1111, Data_b=16'h2222 -> owner per frame: none, A, B, A, B; Seg follows.
REQ-035 A owning; at cycle 20 Data_a changes 4321->8765 and Req_a drops -> rest of frame still shows 4321 with Gnt_a=1; next frame idle, Gnt_a=0.
REQ-036 Reset pulsed at cycle 22 while B owns -> next cycle Sl=1111, Gnt_b=0, counters 0; the following frame is idle.
REQ-037 Data_b=16'hFA0C granted -> Seg shows C,0,A,F unmodified.
